// File: rtl/regfile_reader_pkg.sv
// Shared definitions for the register-file burst reader: default widths,
// register count and the reader FSM state type.
package regfile_reader_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int NUM_REGS       = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_reader_if.sv
// Bundle of the reader's request, register-file read port and output stream
// signals. The master modport is the reader, the slave modport is everything
// around it (requester, register file and stream consumer).
interface regfile_reader_if
    import regfile_reader_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic              abort;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, start_addr, count, abort, rf_rdata, out_ready,
        output rf_raddr, out_valid, out_data, out_addr, out_last, busy, done
    );

    modport slave (
        output start, start_addr, count, abort, rf_rdata, out_ready,
        input  rf_raddr, out_valid, out_data, out_addr, out_last, busy, done
    );

endinterface

// File: rtl/regfile_reader.sv
// Burst reader: walks a run of register-file indices (wrapping at the top)
// and streams each captured value out over a valid/ready handshake.
// cur_addr always points at the next index to capture, so the combinational
// read port already presents the following word when a handshake completes,
// giving one word per cycle under continuous out_ready.
module regfile_reader
    import regfile_reader_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    regfile_reader_if.master bus
);

    localparam int              REGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(REGS);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] TWO     = (ADDR_W + 1)'(2);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   count_clamped;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;

    assign bus.rf_raddr  = cur_addr;
    assign bus.out_data  = data_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Limit the requested length to the number of registers available.
    always_comb begin
        count_clamped = bus.count;
        if (bus.count > MAX_CNT) begin
            count_clamped = MAX_CNT;
        end
    end

    // Burst FSM with all outputs registered; abort beats handshake and start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && (bus.count != '0) && !bus.abort) begin
                        cur_addr  <= bus.start_addr;
                        remaining <= count_clamped;
                        busy_q    <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        valid_q   <= 1'b0;
                        last_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        remaining <= '0;
                    end else begin
                        data_q   <= bus.rf_rdata;
                        addr_q   <= cur_addr;
                        valid_q  <= 1'b1;
                        last_q   <= (remaining == ONE);
                        cur_addr <= cur_addr + 1'b1;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        valid_q   <= 1'b0;
                        last_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        remaining <= '0;
                    end else if (valid_q && bus.out_ready) begin
                        if (remaining == ONE) begin
                            state     <= IDLE;
                            valid_q   <= 1'b0;
                            last_q    <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            remaining <= '0;
                        end else begin
                            data_q    <= bus.rf_rdata;
                            addr_q    <= cur_addr;
                            last_q    <= (remaining == TWO);
                            cur_addr  <= cur_addr + 1'b1;
                            remaining <= remaining - ONE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: a behavioural register file feeds
// the reader, a scoreboard queue holds the words each burst should produce,
// and a per-cycle monitor pops and compares them on every accepted word.
module tb_regfile_reader;
    import regfile_reader_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        last;
    } word_t;

    typedef struct {
        logic [4:0] addr;
        logic [5:0] cnt;
        int         mode;
        int         exp_words;
        int         exp_done;
    } vec_t;

    logic clk;
    logic reset_n;
    logic [31:0] regs [NUM_REGS];

    int tests = 0;
    int fails = 0;
    int rx_count = 0;
    int done_count = 0;
    bit expect_done = 0;
    bit prev_stall = 0;
    logic [31:0] held_data;
    logic [4:0]  held_addr;
    logic        held_last;
    word_t sb[$];
    vec_t vecs[7];

    regfile_reader_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.rf_rdata = regs[bus.rf_raddr];

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something escapes the per-wait bounds.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge once the inputs for the next rising edge are set.
    task automatic sampleOutputs();
        word_t w;
        if (!reset_n) begin
            prev_stall  = 0;
            expect_done = 0;
            return;
        end
        if (bus.done) done_count++;
        if (expect_done) begin
            checkOutput("done_pulse", 32'(bus.done), 32'd1);
            expect_done = 0;
        end else if (bus.done) begin
            checkOutput("unexpected_done", 32'(bus.done), 32'd0);
        end
        if (prev_stall) begin
            checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_data", bus.out_data, held_data);
            checkOutput("stall_addr", 32'(bus.out_addr), 32'(held_addr));
            checkOutput("stall_last", 32'(bus.out_last), 32'(held_last));
            prev_stall = 0;
        end
        if (bus.out_valid && !bus.abort) begin
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL extra_word: got addr 0x%0h data 0x%0h, expected none",
                             bus.out_addr, bus.out_data);
                end else begin
                    w = sb.pop_front();
                    checkOutput("word_data", bus.out_data, w.data);
                    checkOutput("word_addr", 32'(bus.out_addr), 32'(w.addr));
                    checkOutput("word_last", 32'(bus.out_last), 32'(w.last));
                    rx_count++;
                    if (w.last) expect_done = 1;
                end
            end else begin
                prev_stall = 1;
                held_data  = bus.out_data;
                held_addr  = bus.out_addr;
                held_last  = bus.out_last;
            end
        end
    endtask

    task automatic cycle();
        sampleOutputs();
        @(negedge clk);
    endtask

    task automatic pushWord(input logic [4:0] addr, input bit last);
        word_t w;
        w.addr = addr;
        w.data = regs[addr];
        w.last = last;
        sb.push_back(w);
    endtask

    // Issue one burst, queue its expected words, and run it to completion.
    task automatic applyStimulus(input logic [4:0] addr, input logic [5:0] cnt,
                                 input int mode);
        int n;
        int k;
        n = (cnt > 6'd32) ? 32 : int'(cnt);
        for (int i = 0; i < n; i++) pushWord(addr + 5'(i), i == n - 1);
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.count      = cnt;
        bus.out_ready  = (mode == 0);
        cycle();
        bus.start = 1'b0;
        checkOutput("busy_after_start", 32'(bus.busy), 32'(n != 0));
        checkOutput("valid_in_fetch", 32'(bus.out_valid), 32'd0);
        k = 0;
        while ((bus.busy || sb.size() != 0) && k < 200) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (k % 2 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 1 && k == 3) begin
                bus.start      = 1'b1;
                bus.start_addr = 5'd0;
                bus.count      = 6'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (k == 1) checkOutput("first_valid_latency", 32'(bus.out_valid), 32'(n != 0));
            cycle();
            k++;
        end
        bus.start = 1'b0;
        if (k >= 200) begin
            tests++;
            fails++;
            $display("[TB] FAIL burst_timeout: got %0d words pending, expected 0", sb.size());
            sb.delete();
        end
        if (mode == 0 && n != 0) checkOutput("throughput_cycles", 32'(k), 32'(n + 1));
        cycle();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int rx0;
        int dn0;
        int g;

        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000 + 32'(i);
        regs[0] = 32'h0;

        vecs[0] = '{addr: 5'd3,  cnt: 6'd4,  mode: 0, exp_words: 4,  exp_done: 1};
        vecs[1] = '{addr: 5'd30, cnt: 6'd4,  mode: 1, exp_words: 4,  exp_done: 1};
        vecs[2] = '{addr: 5'd9,  cnt: 6'd0,  mode: 0, exp_words: 0,  exp_done: 0};
        vecs[3] = '{addr: 5'd12, cnt: 6'd40, mode: 0, exp_words: 32, exp_done: 1};
        vecs[4] = '{addr: 5'd31, cnt: 6'd2,  mode: 2, exp_words: 2,  exp_done: 1};
        vecs[5] = '{addr: 5'd0,  cnt: 6'd32, mode: 2, exp_words: 32, exp_done: 1};
        vecs[6] = '{addr: 5'd17, cnt: 6'd1,  mode: 0, exp_words: 1,  exp_done: 1};

        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.count      = '0;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state while reset_n is held low.
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_data", bus.out_data, 32'd0);
        checkOutput("reset_addr", 32'(bus.out_addr), 32'd0);
        checkOutput("reset_last", 32'(bus.out_last), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_raddr", 32'(bus.rf_raddr), 32'd0);
        reset_n = 1'b1;

        // Table of bursts; the first starts on the very first edge out of reset.
        for (int v = 0; v < 7; v++) begin
            rx0 = rx_count;
            dn0 = done_count;
            applyStimulus(vecs[v].addr, vecs[v].cnt, vecs[v].mode);
            checkOutput($sformatf("words_v%0d", v), 32'(rx_count - rx0), 32'(vecs[v].exp_words));
            checkOutput($sformatf("dones_v%0d", v), 32'(done_count - dn0), 32'(vecs[v].exp_done));
        end

        // Abort while the second word of an eight-word burst is presented.
        rx0 = rx_count;
        dn0 = done_count;
        pushWord(5'd10, 1'b0);
        bus.start      = 1'b1;
        bus.start_addr = 5'd10;
        bus.count      = 6'd8;
        bus.out_ready  = 1'b1;
        cycle();
        bus.start = 1'b0;
        g = 0;
        while (rx_count == rx0 && g < 20) begin
            cycle();
            g++;
        end
        checkOutput("abort_first_word_seen", 32'(rx_count - rx0), 32'd1);
        checkOutput("abort_second_addr", 32'(bus.out_addr), 32'd11);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_last", 32'(bus.out_last), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        sb.delete();
        repeat (3) cycle();
        checkOutput("abort_no_done", 32'(done_count - dn0), 32'd0);
        bus.out_ready = 1'b0;
        rx0 = rx_count;
        dn0 = done_count;
        applyStimulus(5'd0, 6'd2, 0);
        checkOutput("after_abort_words", 32'(rx_count - rx0), 32'd2);
        checkOutput("after_abort_done", 32'(done_count - dn0), 32'd1);

        // Start together with abort in IDLE is refused.
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        bus.start_addr = 5'd5;
        bus.count      = 6'd3;
        cycle();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput("start_abort_busy", 32'(bus.busy), 32'd0);
        cycle();
        checkOutput("start_abort_valid", 32'(bus.out_valid), 32'd0);

        // A write to a register after its capture must not disturb the held word.
        rx0 = rx_count;
        pushWord(5'd20, 1'b0);
        pushWord(5'd21, 1'b1);
        bus.start      = 1'b1;
        bus.start_addr = 5'd20;
        bus.count      = 6'd2;
        bus.out_ready  = 1'b0;
        cycle();
        bus.start = 1'b0;
        cycle();
        regs[20] = 32'hDEAD_BEEF;
        cycle();
        cycle();
        bus.out_ready = 1'b1;
        g = 0;
        while ((bus.busy || sb.size() != 0) && g < 20) begin
            cycle();
            g++;
        end
        cycle();
        checkOutput("capture_words", 32'(rx_count - rx0), 32'd2);
        regs[20] = 32'h1014;
        bus.out_ready = 1'b0;

        // Asynchronous reset in the middle of a stalled burst.
        dn0 = done_count;
        bus.start      = 1'b1;
        bus.start_addr = 5'd4;
        bus.count      = 6'd8;
        cycle();
        bus.start = 1'b0;
        cycle();
        cycle();
        checkOutput("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_reset_data", bus.out_data, 32'd0);
        checkOutput("async_reset_addr", 32'(bus.out_addr), 32'd0);
        checkOutput("async_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("async_reset_last", 32'(bus.out_last), 32'd0);
        sb.delete();
        @(negedge clk);
        cycle();
        reset_n = 1'b1;
        repeat (3) cycle();
        checkOutput("reset_no_done", 32'(done_count - dn0), 32'd0);
        rx0 = rx_count;
        dn0 = done_count;
        applyStimulus(5'd7, 6'd1, 0);
        checkOutput("post_reset_words", 32'(rx_count - rx0), 32'd1);
        checkOutput("post_reset_done", 32'(done_count - dn0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
